// File: rtl/sram_row_decoder_ctrl.sv
// SRAM row decoder sequencer: precharge pulse, one-hot word-line pulse, done strobe; ROWDEC_OOR_ERR_EN turns out-of-range rows into an err pulse.
// Latency PRE_CYC+WL_CYC+1 cycles accept-to-done; ready only in IDLE with en high, no request queuing.
module sram_row_decoder_ctrl #(
    parameter int AW      = 3,
    parameter int ROWS    = 8,
    parameter int PRE_CYC = 1,
    parameter int WL_CYC  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            req,
    input  logic [AW-1:0]   addr,
    output logic            ready,
    output logic            pre,
    output logic [ROWS-1:0] wl,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRECH  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] PRE_LD = 4'(PRE_CYC - 1);
    localparam logic [3:0] WL_LD  = 4'(WL_CYC - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            pre_q, pre_d;
    logic [ROWS-1:0] wl_q, wl_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            boot_q;
    logic            accept;

`ifdef ROWDEC_OOR_ERR_EN
    localparam logic [AW:0] ROWS_W = (AW+1)'(ROWS);
    logic oor;
    assign oor = {1'b0, addr} >= ROWS_W;
`endif

    // boot_q keeps ready low until the first edge after reset release
    assign ready  = boot_q && (state_q == S_IDLE) && en;
    assign accept = ready && req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = addr;
                    state_d = S_PRECH;
                    cnt_d   = PRE_LD;
`ifdef ROWDEC_OOR_ERR_EN
                    if (oor) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            S_PRECH: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_ACTIVE;
                    cnt_d   = WL_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACTIVE: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register on the transition edge
    always_comb begin
        pre_d  = (state_d == S_PRECH);
        done_d = (state_q == S_ACTIVE) && (state_d == S_DONE);
`ifdef ROWDEC_OOR_ERR_EN
        err_d  = (state_q == S_IDLE) && (state_d == S_DONE);
`else
        err_d  = 1'b0;
`endif
        wl_d = '0;
        for (int i = 0; i < ROWS; i++) begin
            wl_d[i] = (state_d == S_ACTIVE) && (addr_d == AW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            pre_q   <= 1'b0;
            wl_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            boot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            pre_q   <= pre_d;
            wl_q    <= wl_d;
            done_q  <= done_d;
            err_q   <= err_d;
            boot_q  <= 1'b1;
        end
    end

    assign pre  = pre_q;
    assign wl   = wl_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_sram_row_decoder_ctrl.sv
// Scoreboard bench for sram_row_decoder_ctrl: stimulus queues expected accesses, monitor checks each done/err pulse.
module tb_sram_row_decoder_ctrl;

    localparam int AW     = 3;
    localparam int ROWS   = 6;
    localparam int PRE    = 2;
    localparam int WL     = 3;
    localparam int LAT    = PRE + WL + 1;
    localparam int PERIOD = PRE + WL + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            req = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic            ready, pre, done, err;
    logic [ROWS-1:0] wl;

    always #5 clk = ~clk;

    sram_row_decoder_ctrl #(.AW(AW), .ROWS(ROWS), .PRE_CYC(PRE), .WL_CYC(WL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .addr  (addr),
        .ready (ready),
        .pre   (pre),
        .wl    (wl),
        .done  (done),
        .err   (err)
    );

    typedef struct {
        logic            is_err;
        logic [ROWS-1:0] wl;
        int              pre_len;
        int              wl_len;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [ROWS-1:0] onehot(input int a);
        logic [ROWS-1:0] r;
        r = '0;
        if (a < ROWS) r[a] = 1'b1;
        return r;
    endfunction

    function automatic exp_t expect_for(input int a);
        exp_t e;
`ifdef ROWDEC_OOR_ERR_EN
        if (a >= ROWS) begin
            e.is_err = 1'b1; e.wl = '0; e.pre_len = 0; e.wl_len = 0; e.lat = 1;
            return e;
        end
`endif
        e.is_err  = 1'b0;
        e.wl      = onehot(a);
        e.pre_len = PRE;
        e.wl_len  = (a < ROWS) ? WL : 0;
        e.lat     = LAT;
        return e;
    endfunction

    // Issue a request and wait (bounded) for acceptance; returns at accept edge + 1
    task automatic access(input int a, input bit push, output int acc_cyc);
        bit got;
        got  = 1'b0;
        addr = AW'(a);
        req  = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        acc_cyc = cyc;
        if (!got) begin
            chk("accept_timeout", 0, 1);
            req = 1'b0;
        end else begin
            if (push) sb.push_back(expect_for(a));
            @(posedge clk);
            #1;
            req = 1'b0;
        end
    endtask

    // Monitor: tracks pulse lengths since the last acceptance and pops on done/err
    int              mcyc = 0;
    int              acc_m = 0;
    int              pre_len = 0;
    int              wl_len = 0;
    logic [ROWS-1:0] wl_seen = '0;
    exp_t            me;

    always @(negedge clk) begin
        if (rst_n) begin
            mcyc++;
            chk("pre_wl_overlap", int'(pre && (|wl)), 0);
            chk("wl_onehot", int'($countones(wl) <= 1), 1);
            if (pre) pre_len++;
            if (|wl) begin
                if (wl_len > 0) chk("wl_stable", int'(wl), int'(wl_seen));
                wl_len++;
                wl_seen = wl;
            end
            if (done || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", int'({done, err}), 0);
                end else begin
                    me = sb.pop_front();
                    chk("out_kind", int'({done, err}), me.is_err ? 2 'b01 : 2'b10);
                    chk("wl_row", int'(wl_seen), int'(me.wl));
                    chk("pre_len", pre_len, me.pre_len);
                    chk("wl_len", wl_len, me.wl_len);
                    chk("latency", mcyc - acc_m, me.lat);
                end
            end
            if (ready && req) begin
                pre_len = 0;
                wl_len  = 0;
                wl_seen = '0;
                acc_m   = mcyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, c;
        en    = 1'b1;
        rst_n = 1'b0;
        #12;
        chk("rst_ready", int'(ready), 0);
        chk("rst_pre", int'(pre), 0);
        chk("rst_wl", int'(wl), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", int'(ready), 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", int'(ready), 1);

        // Single access, then back-to-back sweep over every row
        access(5, 1'b1, c);
        access(0, 1'b1, prev);
        for (int a = 1; a < ROWS; a++) begin
            access(a, 1'b1, c);
            chk("b2b_period", c - prev, PERIOD);
            prev = c;
        end

        // req held with addr toggling while the row is active
        access(1, 1'b1, prev);
        req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr = AW'(k * 3 + 2);
            @(posedge clk);
            #1;
        end
        access(4, 1'b1, c);
        chk("held_req_period", c - prev, PERIOD);

        // en dropped in the second ACTIVE cycle
        access(2, 1'b0, c);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_wl_active", int'(wl), int'(onehot(2)));
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_wl", int'(wl), 0);
        chk("abort_pre", int'(pre), 0);
        chk("abort_ready", int'(ready), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_ready_hold", int'(ready), 0);
        en = 1'b1;
        #1;
        chk("abort_ready_back", int'(ready), 1);

        // Reset pulse mid-precharge
        access(3, 1'b0, c);
        chk("midrst_pre_high", int'(pre), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pre", int'(pre), 0);
        chk("midrst_wl", int'(wl), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_ready", int'(ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_low", int'(ready), 0);
        @(posedge clk);
        #1;
        chk("midrst_ready_up", int'(ready), 1);

        access(3, 1'b1, c);
        // Out-of-range rows
        access(6, 1'b1, c);
        access(7, 1'b1, c);

        repeat (20) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
